// File: rtl/sram_burst_controller.sv
// sram_burst_controller
// Runs single or incrementing-burst read/write transactions against an
// on-chip single-port array through an IDLE/SETUP/ACCESS/DONE sequence.
// Each beat can be stretched by WAIT_STATES extra ACCESS cycles. The
// active-low strobes are decoded from the registered state for observation.
//
// Optional feature macro: SRAM_MEM_CLEAR_EN
//   defined   -> rst also clears every array location to zero asynchronously
//   undefined -> array contents survive rst
module sram_burst_controller #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ce_n,
  output logic              we_n,
  output logic              oe_n,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int         DEPTH     = 1 << ADDR_W;
  // Wait counter reload value; the counter is 4 bits wide (0..15 wait states).
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]        state;
  logic              is_read;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats_left;
  logic [3:0]        wait_cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic in_access;
  logic xfer;
  logic wr_fire;
  logic rd_fire;

  // The last ACCESS cycle of a beat (wait counter exhausted) is the transfer cycle.
  assign in_access = (state == ST_ACCESS);
  assign xfer      = in_access && (wait_cnt == 4'd0);
  assign wr_fire   = xfer && !is_read;
  assign rd_fire   = xfer && is_read;

  // Transaction sequencer: latches the command in IDLE, then walks the beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      is_read    <= 1'b0;
      cur_addr   <= '0;
      beats_left <= '0;
      wait_cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SETUP;
            is_read    <= rw;
            cur_addr   <= addr;
            beats_left <= len;
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          wait_cnt <= WAIT_INIT;
        end
        ST_ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (beats_left != '0) begin
            // Next beat reuses ACCESS directly; the address wraps naturally.
            cur_addr   <= cur_addr + ADDR_W'(1);
            beats_left <= beats_left - LEN_W'(1);
            wait_cnt   <= WAIT_INIT;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data path: capture the addressed word on a read transfer and pulse rvalid next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_fire;
      if (rd_fire) begin
        rdata <= mem[cur_addr];
      end
    end
  end

`ifdef SRAM_MEM_CLEAR_EN
  // Storage array with asynchronous clear on rst; written on write transfer edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[cur_addr] <= wdata;
    end
  end
`else
  // Storage array without reset; an aborted beat never reaches its write edge.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[cur_addr] <= wdata;
    end
  end
`endif

  // Strobes and status are pure decodes of the registered state.
  assign ce_n     = !((state == ST_SETUP) || in_access);
  assign oe_n     = !(((state == ST_SETUP) || in_access) && is_read);
  assign we_n     = !(in_access && !is_read);
  assign wr_ready = wr_fire;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_sram_burst_controller.sv
// tb_sram_burst_controller
// Table-driven cycle vectors against a default instance, plus hand-written
// sequences for wait states, ignored mid-transaction starts and async reset.
// Expected results follow SRAM_MEM_CLEAR_EN when the bench is built with it.
module tb_sram_burst_controller;

  logic       clk;
  logic       rst;

  // Default instance (WAIT_STATES = 0)
  logic       start, rw;
  logic [3:0] addr;
  logic [2:0] len;
  logic [7:0] wdata;
  logic       wr_ready, rvalid, ce_n, we_n, oe_n, busy, done;
  logic [7:0] rdata;

  // Wait-state instance (WAIT_STATES = 2)
  logic       w2_start, w2_rw;
  logic [3:0] w2_addr;
  logic [2:0] w2_len;
  logic [7:0] w2_wdata;
  logic       w2_wr_ready, w2_rvalid, w2_ce_n, w2_we_n, w2_oe_n, w2_busy, w2_done;
  logic [7:0] w2_rdata;

  int total;
  int bad;

  sram_burst_controller #(.ADDR_W(4), .DATA_W(8), .LEN_W(3), .WAIT_STATES(0)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .wr_ready(wr_ready), .rdata(rdata), .rvalid(rvalid),
    .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n), .busy(busy), .done(done)
  );

  sram_burst_controller #(.ADDR_W(4), .DATA_W(8), .LEN_W(3), .WAIT_STATES(2)) dut_w2 (
    .clk(clk), .rst(rst), .start(w2_start), .rw(w2_rw), .addr(w2_addr), .len(w2_len),
    .wdata(w2_wdata), .wr_ready(w2_wr_ready), .rdata(w2_rdata), .rvalid(w2_rvalid),
    .ce_n(w2_ce_n), .we_n(w2_we_n), .oe_n(w2_oe_n), .busy(w2_busy), .done(w2_done)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle vector: inputs for the coming edge and outputs expected after it.
  // exp packs {ce_n, we_n, oe_n, wr_ready, rvalid, busy, done, rdata}.
  typedef struct {
    logic        start;
    logic        rw;
    logic [3:0]  addr;
    logic [2:0]  len;
    logic [7:0]  wdata;
    logic [14:0] exp;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mkvec(input logic st, input logic r, input logic [3:0] a,
                                 input logic [2:0] l, input logic [7:0] wd,
                                 input logic [6:0] strobes, input logic [7:0] rd);
    vec_t v;
    v.start = st;
    v.rw    = r;
    v.addr  = a;
    v.len   = l;
    v.wdata = wd;
    v.exp   = {strobes, rd};
    return v;
  endfunction

  function automatic logic [14:0] outs0();
    return {ce_n, we_n, oe_n, wr_ready, rvalid, busy, done, rdata};
  endfunction

  function automatic logic [14:0] outs2();
    return {w2_ce_n, w2_we_n, w2_oe_n, w2_wr_ready, w2_rvalid, w2_busy, w2_done, w2_rdata};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start = v.start;
    rw    = v.rw;
    addr  = v.addr;
    len   = v.len;
    wdata = v.wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Burst write on the default instance; beat i data is d[8*i +: 8].
  task automatic write_burst(input logic [3:0] a, input logic [2:0] l, input logic [31:0] d,
                             input string tag);
    int beat;
    int cyc;
    logic seen_done;
    start = 1'b1; rw = 1'b0; addr = a; len = l; wdata = 8'h00;
    tick();
    start = 1'b0;
    beat = 0; cyc = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 60) begin
      if (wr_ready) begin
        wdata = d[8*beat +: 8];
        beat++;
      end
      tick();
      cyc++;
      seen_done = done;
    end
    checkOutput({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    checkOutput({tag, "_beats"}, 32'(beat), 32'(l) + 32'd1);
    tick();
  endtask

  // Burst read on the default instance; captured beat i lands in got[8*i +: 8].
  task automatic read_burst(input logic [3:0] a, input logic [2:0] l,
                            output logic [31:0] got, output int n, input string tag);
    int cyc;
    logic seen_done;
    got = 32'h0; n = 0;
    start = 1'b1; rw = 1'b1; addr = a; len = l;
    tick();
    start = 1'b0;
    cyc = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 60) begin
      tick();
      cyc++;
      if (rvalid) begin
        if (n < 4) got[8*n +: 8] = rdata;
        n++;
      end
      seen_done = done;
    end
    checkOutput({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    tick();
  endtask

  // Test sequence
  initial begin
    logic [31:0] got;
    int          n;
    int          busy_cnt, wr_cnt, wr_at, oe_cnt, done_cnt, done_at, rv_cnt, rv_at;
    logic [7:0]  rv_data;
    logic [7:0]  exp8, exp9, exp5;

    total = 0; bad = 0;
    rst = 1'b1;
    start = 1'b0; rw = 1'b0; addr = 4'h0; len = 3'd0; wdata = 8'h00;
    w2_start = 1'b0; w2_rw = 1'b0; w2_addr = 4'h0; w2_len = 3'd0; w2_wdata = 8'h00;

    // ---- Cycle vectors for the default instance ----
    //                 st  rw  addr  len  wdata  {ce,we,oe,wr,rv,bsy,dn}  rdata
    vecs[0]  = mkvec(1, 0, 4'h5, 3'd0, 8'hAA, 7'b0110010, 8'h00); // SETUP write
    vecs[1]  = mkvec(0, 0, 4'h5, 3'd0, 8'hAA, 7'b0011010, 8'h00); // ACCESS write
    vecs[2]  = mkvec(0, 0, 4'h5, 3'd0, 8'hAA, 7'b1110011, 8'h00); // DONE
    vecs[3]  = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b1110000, 8'h00); // IDLE
    vecs[4]  = mkvec(1, 1, 4'h5, 3'd0, 8'h00, 7'b0100010, 8'h00); // SETUP read
    vecs[5]  = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b0100010, 8'h00); // ACCESS read
    vecs[6]  = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b1110111, 8'hAA); // DONE + rvalid
    vecs[7]  = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b1110000, 8'hAA); // IDLE
    vecs[8]  = mkvec(1, 0, 4'hE, 3'd3, 8'h00, 7'b0110010, 8'hAA); // SETUP burst write
    vecs[9]  = mkvec(1, 1, 4'h3, 3'd0, 8'h00, 7'b0011010, 8'hAA); // beat E (start ignored)
    vecs[10] = mkvec(0, 0, 4'h0, 3'd0, 8'h11, 7'b0011010, 8'hAA); // beat F
    vecs[11] = mkvec(0, 0, 4'h0, 3'd0, 8'h22, 7'b0011010, 8'hAA); // beat 0
    vecs[12] = mkvec(0, 0, 4'h0, 3'd0, 8'h33, 7'b0011010, 8'hAA); // beat 1
    vecs[13] = mkvec(0, 0, 4'h0, 3'd0, 8'h44, 7'b1110011, 8'hAA); // DONE
    vecs[14] = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b1110000, 8'hAA); // IDLE
    vecs[15] = mkvec(1, 1, 4'hE, 3'd3, 8'h00, 7'b0100010, 8'hAA); // SETUP burst read
    vecs[16] = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b0100010, 8'hAA); // beat E
    vecs[17] = mkvec(1, 0, 4'h2, 3'd1, 8'h00, 7'b0100110, 8'h11); // beat F (start ignored)
    vecs[18] = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b0100110, 8'h22); // beat 0
    vecs[19] = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b0100110, 8'h33); // beat 1
    vecs[20] = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b1110111, 8'h44); // DONE + last rvalid
    vecs[21] = mkvec(0, 0, 4'h0, 3'd0, 8'h00, 7'b1110000, 8'h44); // IDLE

    // ---- Reset state ----
    repeat (3) @(negedge clk);
    checkOutput("reset_outs", 32'(outs0()), 32'h7000);
    checkOutput("reset_outs_w2", 32'(outs2()), 32'h7000);
    rst = 1'b0;
    tick();
    checkOutput("idle_after_reset", 32'(outs0()), 32'h7000);

    // ---- Table-driven vectors ----
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d", i), 32'(outs0()), 32'(vecs[i].exp));
    end
    start = 1'b0;

    // ---- Wait-state instance: single write then single read with a stray start ----
    w2_start = 1'b1; w2_rw = 1'b0; w2_addr = 4'h7; w2_len = 3'd0; w2_wdata = 8'h5C;
    busy_cnt = 0; wr_cnt = 0; wr_at = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      w2_start = 1'b0;
      if (w2_busy) busy_cnt++;
      if (w2_wr_ready) begin wr_cnt++; wr_at = c; end
    end
    checkOutput("w2_wr_busy_cycles", 32'(busy_cnt), 32'd5);
    checkOutput("w2_wr_ready_count", 32'(wr_cnt), 32'd1);
    checkOutput("w2_wr_ready_cycle", 32'(wr_at), 32'd3);

    w2_start = 1'b1; w2_rw = 1'b1; w2_addr = 4'h7; w2_len = 3'd0; w2_wdata = 8'h00;
    busy_cnt = 0; oe_cnt = 0; done_cnt = 0; done_at = -1; rv_cnt = 0; rv_at = -1; rv_data = 8'h00;
    for (int c = 0; c < 10; c++) begin
      tick();
      // Stray command mid-transaction, live for exactly one edge
      w2_start = (c == 2);
      w2_rw    = 1'b0;
      if (w2_busy) busy_cnt++;
      if (!w2_oe_n) oe_cnt++;
      if (w2_done) begin done_cnt++; done_at = c; end
      if (w2_rvalid) begin rv_cnt++; rv_at = c; rv_data = w2_rdata; end
    end
    w2_start = 1'b0;
    checkOutput("w2_rd_busy_cycles", 32'(busy_cnt), 32'd5);
    checkOutput("w2_rd_oe_cycles", 32'(oe_cnt), 32'd4);
    checkOutput("w2_rd_done_count", 32'(done_cnt), 32'd1);
    checkOutput("w2_rd_done_cycle", 32'(done_at), 32'd4);
    checkOutput("w2_rd_rvalid_count", 32'(rv_cnt), 32'd1);
    checkOutput("w2_rd_rvalid_cycle", 32'(rv_at), 32'd4);
    checkOutput("w2_rd_data", 32'(rv_data), 32'h5C);

    // ---- Async reset in the middle of a 4-beat write ----
    write_burst(4'h8, 3'd3, 32'h84838281, "pre_wr");
    read_burst(4'h8, 3'd3, got, n, "pre_rd");
    checkOutput("pre_rd_beats", 32'(n), 32'd4);
    checkOutput("pre_rd_data", got, 32'h84838281);

    start = 1'b1; rw = 1'b0; addr = 4'h8; len = 3'd3; wdata = 8'h00;
    tick();                       // SETUP
    start = 1'b0;
    tick();                       // beat 0 (addr 8) transfer cycle
    checkOutput("abort_beat0_wr_ready", 32'(wr_ready), 32'd1);
    wdata = 8'h91;
    tick();                       // beat 1 (addr 9) transfer cycle, 0x91 stored
    checkOutput("abort_beat1_wr_ready", 32'(wr_ready), 32'd1);
    wdata = 8'h92;
    #2 rst = 1'b1;
    #1 checkOutput("abort_async_outs", 32'(outs0()), 32'h7000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_held_outs", 32'(outs0()), 32'h7000);
    rst = 1'b0;
    tick();

`ifdef SRAM_MEM_CLEAR_EN
    exp8 = 8'h00; exp9 = 8'h00; exp5 = 8'h00;
`else
    exp8 = 8'h91; exp9 = 8'h82; exp5 = 8'hAA;
`endif
    read_burst(4'h8, 3'd1, got, n, "post_rd");
    checkOutput("post_rd_beats", 32'(n), 32'd2);
    checkOutput("post_rd_addr8", 32'(got[7:0]), 32'(exp8));
    checkOutput("post_rd_addr9", 32'(got[15:8]), 32'(exp9));
    read_burst(4'h5, 3'd0, got, n, "post_rd5");
    checkOutput("post_rd5_data", 32'(got[7:0]), 32'(exp5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_burst_controller.md
# sram_burst_controller

Parametrised controller for an on-chip single-port SRAM array (2^ADDR_W × DATA_W) that runs single or incrementing-burst read/write transactions through a SETUP/ACCESS/DONE sequence with programmable wait states. It sits between a simple start/rw command port and the storage array. It exposes active-low SRAM-style strobes (ce_n, we_n, oe_n) for observation and downstream timing checks.

## Interface
- ADDR_W, 4, address width; array depth = 2**ADDR_W
- DATA_W, 8, data width
- LEN_W, 3, burst-length field width; max burst = 2**LEN_W beats
- WAIT_STATES, 0, extra ACCESS cycles per beat (0..15)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  command request; accepted only when busy=0
- rw  in  1  1 = read, 0 = write; sampled with start
- addr  in  ADDR_W  burst start address; sampled with start
- len  in  LEN_W  beats minus one; sampled with start
- wdata  in  DATA_W  write data for the current beat; sampled when wr_ready=1
- wr_ready  out  1  write beat consumed at this clock edge
- rdata  out  DATA_W  read data, valid when rvalid=1
- rvalid  out  1  one-cycle pulse per read beat
- ce_n, we_n, oe_n  out  1 each  active-low chip-enable, write-enable, output-enable
- busy  out  1  transaction in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse marking transaction end

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: start=1 latches rw/addr/len, sets beat counter = len, goes to SETUP. start=0 stays.
- SETUP: exactly one cycle, then ACCESS with wait counter = WAIT_STATES.
- ACCESS: lasts WAIT_STATES+1 cycles. The final cycle is the transfer cycle:
  - Write: wr_ready=1; mem[addr] <= wdata at the edge.
  - Read: rdata <= mem[addr]; rvalid=1 in the following cycle.
  - If beats remain: addr <= addr+1 mod 2**ADDR_W (wrap-around), counter decrements, ACCESS re-entered without a new SETUP.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Strobes are decoded from the registered state only:
  - ce_n=0 in SETUP and ACCESS.
  - oe_n=0 in SETUP and ACCESS when reading.
  - we_n=0 in ACCESS when writing.
  - All strobes high in IDLE and DONE.
- start while busy=1 is ignored; no queuing.
- rw/addr/len/wdata changes mid-transaction have no effect except wdata at wr_ready edges.
- Memory array has no reset, except as described under Configuration.

## Timing
- Reset values: ce_n=we_n=oe_n=1, wr_ready=0, rvalid=0, done=0, busy=0, rdata=0, state=IDLE.
- Reset takes effect asynchronously, including mid-burst. An interrupted write beat not yet at its wr_ready edge is not stored.
- Start accepted at edge T0:
  - SETUP during cycle T0..T1.
  - Beat k transfer cycle ends at edge T1 + (k+1)·(WAIT_STATES+1).
  - DONE cycle follows the last transfer.
- Total busy cycles = 2 + N·(WAIT_STATES+1), where N = len+1. For a single beat with WAIT_STATES=0: busy 3 cycles.
- Last read beat: rvalid and done are asserted in the same cycle.
- A new start may be sampled in the first IDLE cycle after DONE; back-to-back gap is one cycle.

## Configuration
- SRAM_MEM_CLEAR_EN defined: rst also clears every array location to 0 asynchronously.
- SRAM_MEM_CLEAR_EN undefined: array contents survive rst (unknown at power-up); all other reset behaviour is identical.

## Test plan
- Defaults. Write addr 5, 0xAA, len 0 -> SETUP then ACCESS with we_n=0 and wr_ready=1 for 1 cycle; done pulse 3 cycles after start edge; busy high 3 cycles.
- Read addr 5, len 0 -> oe_n=0 for 2 cycles; rvalid=1 with rdata=0xAA in the same cycle as done.
- Burst write addr 0xE, len 3, wdata 0x11/0x22/0x33/0x44 at successive wr_ready -> locations E,F,0,1 hold these values (wrap). Burst read of the same range -> 4 rvalid pulses in order; ce_n low throughout, no SETUP between beats.
- WAIT_STATES=2 instance, single read -> ACCESS held 3 cycles; done 5 cycles after start. A start pulse issued mid-transaction is ignored: exactly one done, no extra rvalid.
- rst asserted during beat 2 of a 4-beat write -> all outputs at reset values immediately. Then:
  - Next read of the interrupted beat's address returns its prior contents; data from beats before rst is retained.
  - With SRAM_MEM_CLEAR_EN defined, a read of any location after rst returns 0x00.
